// File: rtl/fpu_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_addsub_ctrl
//
// Sequencing wrapper around an external combinational single-precision
// add/sub datapath. It buffers requests in a 2-entry FIFO and feeds one
// operation at a time to the adder. It then applies IEEE-754 special-case
// handling (NaN, infinity, overflow) to the adder output. The final result
// is held in output registers until the consumer takes it.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready : request handshake; in_frs1, in_frs2, in_funct
//                       (0=add, 1=sub frs1-frs2), in_rd (destination tag)
//   add_frs1/2, add_funct, add_en : operands and enable to the external adder
//   add_frd           : adder result, valid in the same cycle
//   out_valid/out_ready : result handshake; out_frd, out_rd,
//                       out_fflags {NV,DZ,OF,UF,NX}
//   busy              : FIFO non-empty or an operation in flight
//
// Only XLEN=32 (binary32) is supported. The field slicing below assumes that
// width.
// ---------------------------------------------------------------------------
module fpu_addsub_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_frs1,
    input  logic [XLEN-1:0] in_frs2,
    input  logic            in_funct,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] add_frs1,
    output logic [XLEN-1:0] add_frs2,
    output logic            add_funct,
    output logic            add_en,
    input  logic [XLEN-1:0] add_frd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_frd,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_fflags,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // A FIFO entry holds {frs1, frs2, funct, rd}.
    localparam int EW = 2 * XLEN + 6;

    localparam logic [XLEN-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [XLEN-1:0] POS_INF  = 32'h7F80_0000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [EW-1:0]   fifo_mem_q [0:1];
    logic [EW-1:0]   fifo_mem_d [0:1];
    logic            fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic            fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    // Held low through reset so in_ready only rises on the first edge
    // after reset is released.
    logic            rdy_en_q, rdy_en_d;

    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic            funct_q, funct_d;
    logic [4:0]      tag_q, tag_d;

    logic [XLEN-1:0] res_frd_q, res_frd_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic [4:0]      res_flags_q, res_flags_d;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   fifo_head;

    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign in_ready   = rdy_en_q & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign fifo_head  = fifo_mem_q[fifo_rd_ptr_q];

    always_comb begin
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        rdy_en_d      = 1'b1;
        if (push) begin
            fifo_wr_ptr_d = ~fifo_wr_ptr_q;
        end
        if (pop) begin
            fifo_rd_ptr_d = ~fifo_rd_ptr_q;
        end
        // Simultaneous push and pop leave the count unchanged.
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_comb begin
                fifo_mem_d[gi] = fifo_mem_q[gi];
                if (push && (fifo_wr_ptr_q == gi[0])) begin
                    fifo_mem_d[gi] = {in_frs1, in_frs2, in_funct, in_rd};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_mem_q[gi] <= '0;
                end else begin
                    fifo_mem_q[gi] <= fifo_mem_d[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand registers load from the FIFO head on every pop and otherwise
    // hold. They directly drive the adder inputs.
    always_comb begin
        op1_d   = op1_q;
        op2_d   = op2_q;
        funct_d = funct_q;
        tag_d   = tag_q;
        if (pop) begin
            op1_d   = fifo_head[EW-1 -: XLEN];
            op2_d   = fifo_head[EW-1-XLEN -: XLEN];
            funct_d = fifo_head[5];
            tag_d   = fifo_head[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Special-case resolution on the operand registers
    // ------------------------------------------------------------------
    logic       op1_nan, op2_nan, op1_snan, op2_snan, op1_inf, op2_inf;
    logic       op2_sign_eff;
    logic       eff_sub;
    logic [XLEN-1:0] fix_frd;
    logic [4:0]      fix_flags;

    assign op1_nan  = (&op1_q[30:23]) & (|op1_q[22:0]);
    assign op2_nan  = (&op2_q[30:23]) & (|op2_q[22:0]);
    assign op1_snan = op1_nan & ~op1_q[22];
    assign op2_snan = op2_nan & ~op2_q[22];
    assign op1_inf  = (&op1_q[30:23]) & ~(|op1_q[22:0]);
    assign op2_inf  = (&op2_q[30:23]) & ~(|op2_q[22:0]);
    // Subtraction is addition of frs2 with its sign flipped.
    assign op2_sign_eff = op2_q[31] ^ funct_q;
    assign eff_sub      = op1_q[31] ^ op2_sign_eff;

    always_comb begin
        fix_frd   = add_frd;
        fix_flags = 5'b00000;
        if (op1_nan || op2_nan) begin
            fix_frd      = QNAN;
            fix_flags[4] = op1_snan | op2_snan;
        end else if (op1_inf && op2_inf && eff_sub) begin
            fix_frd      = QNAN;
            fix_flags[4] = 1'b1;
        end else if (op1_inf) begin
            // Covers both-infinite with effective addition: both infinities
            // carry the same effective sign, so frs1 is the answer.
            fix_frd = op1_q;
        end else if (op2_inf) begin
            fix_frd = {op2_sign_eff, POS_INF[30:0]};
        end else if (&add_frd[30:23]) begin
            // Finite inputs but the adder saturated: force a clean infinity
            // and report overflow plus inexact.
            fix_frd      = {add_frd[31], POS_INF[30:0]};
            fix_flags[2] = 1'b1;
            fix_flags[0] = 1'b1;
        end
    end

    // Result registers capture only in EXEC and stay stable through WB.
    always_comb begin
        res_frd_d   = res_frd_q;
        res_rd_d    = res_rd_q;
        res_flags_d = res_flags_q;
        if (state_q == ST_EXEC) begin
            res_frd_d   = fix_frd;
            res_rd_d    = tag_q;
            res_flags_d = fix_flags;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            rdy_en_q      <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            funct_q       <= 1'b0;
            tag_q         <= 5'd0;
            res_frd_q     <= '0;
            res_rd_q      <= 5'd0;
            res_flags_q   <= 5'd0;
        end else begin
            state_q       <= state_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rdy_en_q      <= rdy_en_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            funct_q       <= funct_d;
            tag_q         <= tag_d;
            res_frd_q     <= res_frd_d;
            res_rd_q      <= res_rd_d;
            res_flags_q   <= res_flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign add_frs1   = op1_q;
    assign add_frs2   = op2_q;
    assign add_funct  = funct_q;
    assign add_en     = (state_q == ST_EXEC);
    assign out_valid  = (state_q == ST_WB);
    assign out_frd    = res_frd_q;
    assign out_rd     = res_rd_q;
    assign out_fflags = res_flags_q;
    assign busy       = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
module tb_fpu_addsub_ctrl;

    localparam int NVEC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_frs1;
    logic [31:0] in_frs2;
    logic        in_funct;
    logic [4:0]  in_rd;
    logic [31:0] add_frs1;
    logic [31:0] add_frs2;
    logic        add_funct;
    logic        add_en;
    logic [31:0] add_frd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_frd;
    logic [4:0]  out_rd;
    logic [4:0]  out_fflags;
    logic        busy;

    always #5 clk = ~clk;

    fpu_addsub_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frs1    (in_frs1),
        .in_frs2    (in_frs2),
        .in_funct   (in_funct),
        .in_rd      (in_rd),
        .add_frs1   (add_frs1),
        .add_frs2   (add_frs2),
        .add_funct  (add_funct),
        .add_en     (add_en),
        .add_frd    (add_frd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frd    (out_frd),
        .out_rd     (out_rd),
        .out_fflags (out_fflags),
        .busy       (busy)
    );

    // Stand-in for the combinational adder: exact answers for the finite
    // cases the vectors rely on, a recognisable finite pattern otherwise.
    function automatic logic [31:0] adder_model(logic [31:0] a, logic [31:0] b, logic f);
        if (a == 32'h3F800000 && b == 32'h40000000 && !f) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3F800000 &&  f) return 32'h40000000;
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !f) return 32'h7F800000;
        if (a == 32'hFF7FFFFF && b == 32'hFF7FFFFF && !f) return 32'hFF800000;
        if (a == 32'h7F000000 && b == 32'h7F000000 && !f) return 32'h7FC12345;
        return {f, 8'h80, a[22:0] ^ b[22:0]};
    endfunction

    assign add_frd = adder_model(add_frs1, add_frs2, add_funct);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        logic [4:0]  rd;
        logic [31:0] exp_frd;
        logic [4:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [31:0] frd;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    exp_t pend;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_tag(int i, logic [4:0] rd);
        in_valid = 1'b1;
        in_frs1  = vecs[i].a;
        in_frs2  = vecs[i].b;
        in_funct = vecs[i].f;
        in_rd    = rd;
        pend     = '{vecs[i].exp_frd, rd, vecs[i].exp_flags};
    endtask

    task automatic drive(int i);
        drive_tag(i, vecs[i].rd);
    endtask

    // One clock: handshakes are decided from the settled pre-edge values,
    // the scoreboard is updated and results compared just after the edge.
    task automatic cycle();
        logic acc, done;
        logic [31:0] f;
        logic [4:0] r, fl;
        exp_t e;
        acc  = in_valid && in_ready;
        done = out_valid && out_ready;
        f = out_frd; r = out_rd; fl = out_fflags;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(pend);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got rd=%0d frd=%h expected no result", r, f);
            end else begin
                e = sb.pop_front();
                $display("result rd=%0d frd=%h fflags=%h (expected rd=%0d frd=%h fflags=%h)",
                         r, f, fl, e.rd, e.frd, e.flags);
                chk("out_frd", f, e.frd);
                chk("out_rd", {27'd0, r}, {27'd0, e.rd});
                chk("out_fflags", {27'd0, fl}, {27'd0, e.flags});
            end
        end
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, (sb.size() == 0 && !busy) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Single request into an idle block: checks the exact cycle timing.
    task automatic latency(int i);
        out_ready = 1'b1;
        drive(i);
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        in_valid = 1'b0;
        chk("lat_n_out_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_n_busy", {31'd0, busy}, 32'd1);
        chk("lat_n_add_en", {31'd0, add_en}, 32'd0);
        cycle();
        chk("lat_exec_add_en", {31'd0, add_en}, 32'd1);
        chk("lat_exec_add_frs1", add_frs1, vecs[i].a);
        chk("lat_exec_add_frs2", add_frs2, vecs[i].b);
        chk("lat_exec_add_funct", {31'd0, add_funct}, {31'd0, vecs[i].f});
        chk("lat_exec_out_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("lat_wb_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_wb_add_en", {31'd0, add_en}, 32'd0);
        cycle();
        chk("lat_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int n;
        logic acc;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 5'd5,  32'h40400000, 5'h00};
        vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 5'd6,  32'h40000000, 5'h00};
        vecs[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 5'd7,  32'h7FC00000, 5'h10};
        vecs[3]  = '{32'h7F800001, 32'h3F800000, 1'b0, 5'd8,  32'h7FC00000, 5'h10};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd9,  32'h7F800000, 5'h05};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 5'd10, 32'h7FC00000, 5'h00};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 5'd11, 32'h7FC00000, 5'h10};
        vecs[7]  = '{32'h7F800000, 32'hFF800000, 1'b1, 5'd12, 32'h7F800000, 5'h00};
        vecs[8]  = '{32'h3F800000, 32'h7F800000, 1'b1, 5'd13, 32'hFF800000, 5'h00};
        vecs[9]  = '{32'h3F800000, 32'hFF800000, 1'b0, 5'd14, 32'hFF800000, 5'h00};
        vecs[10] = '{32'hFF800000, 32'h40000000, 1'b0, 5'd15, 32'hFF800000, 5'h00};
        vecs[11] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 5'd16, 32'hFF800000, 5'h05};
        vecs[12] = '{32'h7F000000, 32'h7F000000, 1'b0, 5'd17, 32'h7F800000, 5'h05};
        vecs[13] = '{32'h3F800000, 32'hFFC00001, 1'b0, 5'd18, 32'h7FC00000, 5'h00};
        vecs[14] = '{32'h3F800000, 32'hFF800001, 1'b0, 5'd19, 32'h7FC00000, 5'h10};
        vecs[15] = '{32'hFF800000, 32'h7FC00000, 1'b0, 5'd20, 32'h7FC00000, 5'h00};
        vecs[16] = '{32'h00400000, 32'h00000001, 1'b1, 5'd21, 32'hC0400001, 5'h00};
        vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b0, 5'd22, 32'h7F800000, 5'h00};
        vecs[18] = '{32'hFF800000, 32'h7F800000, 1'b1, 5'd23, 32'hFF800000, 5'h00};
        vecs[19] = '{32'h00000000, 32'h00000000, 1'b0, 5'd24, 32'h40000000, 5'h00};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_frs1 = '0; in_frs2 = '0; in_funct = 1'b0; in_rd = '0;
        pend = '{32'd0, 5'd0, 5'd0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_add_en", {31'd0, add_en}, 32'd0);
        chk("rst_out_frd", out_frd, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_fflags", {27'd0, out_fflags}, 32'd0);
        chk("rst_add_frs1", add_frs1, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("in_ready_before_first_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_first_edge", {31'd0, in_ready}, 32'd1);

        // Single-request latency with the directed examples
        latency(0);
        latency(1);
        latency(2);
        latency(3);
        latency(4);

        // Backpressure: rd1 in WB, rd2/rd3 queued, rd4 refused
        out_ready = 1'b0;
        drive_tag(0, 5'd1); cycle();
        drive_tag(1, 5'd2); cycle();
        drive_tag(4, 5'd3); cycle();
        drive_tag(2, 5'd4);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_out_rd", {27'd0, out_rd}, 32'd1);
        chk("bp_queued", sb.size(), 32'd3);
        repeat (3) cycle();
        chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_out_frd", out_frd, 32'h40400000);
        chk("bp_hold_out_rd", {27'd0, out_rd}, 32'd1);
        chk("bp_rd4_refused", sb.size(), 32'd3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("bp_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
        drain("bp");

        // Full table, streamed with random backpressure
        idx = 0; n = 0;
        while ((idx < NVEC || sb.size() != 0 || busy) && n < 2000) begin
            if (idx < NVEC) drive(idx);
            else in_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            cycle();
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        chk("stream_complete", (idx == NVEC && sb.size() == 0) ? 32'd1 : 32'd0, 32'd1);

        // Throughput: eight requests, consumer always ready
        out_ready = 1'b1;
        idx = 0; n = 0;
        while ((idx < 8 || sb.size() != 0 || busy) && n < 200) begin
            if (idx < 8) drive(idx);
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            cycle();
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        chk("throughput_cycles", n, 32'd18);

        // Reset during EXEC with one entry queued
        out_ready = 1'b1;
        drive(0); cycle();
        drive(1); cycle();
        in_valid = 1'b0;
        chk("mid_exec_add_en", {31'd0, add_en}, 32'd1);
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_add_en", {31'd0, add_en}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) cycle();
        chk("post_rst_no_stale", {31'd0, out_valid | busy}, 32'd0);
        latency(1);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_ctrl.md
FPU_ADDSUB_CTRL -- requirements
Module: fpu_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand/result width; only 32 is supported.
REQ-002 The block SHALL have the following ports:
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  in_valid  in  1  request valid.
  in_ready  out  1  request accepted when in_valid&in_ready at the clk edge.
  in_frs1  in  XLEN  operand 1.
  in_frs2  in  XLEN  operand 2.
  in_funct  in  1  0=add, 1=sub (frs1-frs2).
  in_rd  in  5  destination tag.
  add_frs1  out  XLEN  operand 1 to the combinational adder.
  add_frs2  out  XLEN  operand 2 to the combinational adder.
  add_funct  out  1  op select to the adder.
  add_en  out  1  adder enable.
  add_frd  in  XLEN  adder result, valid in the same cycle.
  out_valid  out  1  result valid.
  out_ready  in  1  consumer ready.
  out_frd  out  XLEN  result.
  out_rd  out  5  destination tag.
  out_fflags  out  5  {NV,DZ,OF,UF,NX}.
  busy  out  1  FIFO non-empty or state!=IDLE.
REQ-003 Clock and reset SHALL be one clock with an asynchronous active-high reset, as stated above.

Function
REQ-004 Input buffering SHALL use a 2-entry FIFO of {frs1,frs2,funct,rd}.
  - in_ready = !full.
  - Push and pop in the same cycle both take effect; count is unchanged.
  - in_valid while full is ignored, with no state change.
REQ-005 The FSM SHALL have three states:
  - IDLE: FIFO non-empty -> pop head into the operand registers, go to EXEC.
  - EXEC: exactly one cycle; add_en=1; capture result, tag and flags into the output registers; go to WB.
  - WB: out_valid=1. On out_valid&out_ready: if FIFO non-empty, pop and go to EXEC, else go to IDLE. Otherwise hold all outputs stable.
REQ-006 Latency SHALL be: accept at edge N into an empty FIFO in IDLE -> EXEC after edge N+1 -> out_valid=1 after edge N+2.
  - Sustained throughput is one result per 2 cycles when out_ready=1.
REQ-007 add_frs1, add_frs2 and add_funct SHALL be driven from the operand registers.
  - add_en=0 outside EXEC.
REQ-008 Special-case operands SHALL be handled before the adder result is used, in this priority order:
  - Either operand is NaN (exp=0xFF, mant!=0): result 0x7FC00000; NV=1 iff either operand is sNaN (mant[22]=0).
  - Both operands are infinite with an effective subtraction (signs differ for add, equal for sub): result 0x7FC00000, NV=1.
  - Exactly one operand is infinite, or both are infinite with an effective addition: result is that infinity. For sub with frs2 infinite, the sign of frs2 is inverted.
  - Otherwise: result = add_frd.
REQ-009 If both operands are finite and add_frd has exp=0xFF, the result SHALL be {add_frd[31],0x7F800000[30:0]} with OF=1 and NX=1.
REQ-010 DZ and UF SHALL always be 0. NX SHALL be 0 except as set by REQ-009.
REQ-011 out_rd SHALL equal the rd of the operation whose result is presented.
  - Results SHALL be delivered in acceptance order.

Reset
REQ-012 While rst=1, asynchronously:
  - FSM = IDLE, FIFO empty.
  - in_ready=0. in_ready=1 from the first edge after rst deasserts.
  - out_valid=0, out_frd=0, out_rd=0, out_fflags=0.
  - add_* outputs = 0, busy=0.
REQ-013 Reset asserted mid-operation SHALL discard all queued and in-flight operations. No result for them is ever presented.

Verification
REQ-014 in_frs1=0x3F800000, in_frs2=0x40000000, funct=0, rd=5, out_ready=1 -> two cycles after accept: out_frd=0x40400000, out_rd=5, out_fflags=0.
REQ-015 in_frs1=0x40400000, in_frs2=0x3F800000, funct=1 -> out_frd=0x40000000, out_fflags=0.
REQ-016 in_frs1=0x7F800000, in_frs2=0xFF800000, funct=0 -> out_frd=0x7FC00000, out_fflags=0x10. Same with in_frs1=0x7F800001, in_frs2=0x3F800000 -> 0x7FC00000, out_fflags=0x10.
REQ-017 out_ready=0, four back-to-back requests with rd=1..4:
  - rd1 reaches WB; rd2 and rd3 fill the FIFO; in_ready=0 and rd4 is not accepted.
  - With out_ready then 1: results rd1, rd2, rd3 in order; in_ready=1 again after the first pop.
REQ-018 Finite overflow: in_frs1=in_frs2=0x7F7FFFFF, funct=0, with the adder returning exp=0xFF -> out_frd=0x7F800000, out_fflags=0x05.
REQ-019 Reset mid-operation: assert rst during EXEC with one FIFO entry queued -> out_valid=0 and busy=0 immediately. After release, no stale result appears and a new request completes with normal latency.
